// File: rtl/fifo_serial_tx.sv
// Drains a FIFO one word at a time and serialises each word as
// start / data (LSB first) / optional parity / stop bits on a single line.
module fifo_serial_tx #(
    parameter int DWIDTH       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_read_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DWIDTH + STOP_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DWIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              rd_q, rd_d;
    logic              done_q, done_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (enable && !fifo_empty) begin
                    state_d = READ;
                    rd_d    = 1'b1;
                end
            end
            READ: state_d = LOAD;
            LOAD: begin
                shift_d = fifo_data;
                par_d   = (^fifo_data) ^ 1'(PARITY_ODD);
                tx_d    = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // shift_q[0] is on the line; the next bit is shift_q[1]
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    assign fifo_read_en = rd_q;
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = done_q;
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Three framing variants driven from shared enable/reset, each with its own
// queue-backed FIFO and a cycle-count model of the expected line waveform.
module tb_fifo_serial_tx;
    localparam int NI  = 3;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wire [NI-1:0] tx_w, rd_w, busy_w, done_w;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] frame_of(input logic [3:0] w, input int pe,
                                             input int po);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int j = 0; j < 4; j++) f[1+j] = w[j];
        if (pe != 0) f[5] = (^w) ^ (po != 0);
        return f;
    endfunction

    for (genvar i = 0; i < NI; i++) begin : g_inst
        localparam int PE = (i == 0) ? 0 : 1;
        localparam int PO = (i == 2) ? 1 : 0;
        localparam int SB = (i == 1) ? 2 : 1;
        localparam int FLEN = (1 + 4 + PE + SB) * CPB;

        logic [3:0] fq[$];
        logic [3:0] fd = 4'h0;
        logic       fe = 1'b1;
        logic       pop_now = 1'b0;

        fifo_serial_tx #(.DWIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(PE),
                         .PARITY_ODD(PO), .STOP_BITS(SB)) u_dut (
            .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fe), .fifo_data(fd),
            .fifo_read_en(rd_w[i]), .tx(tx_w[i]), .busy(busy_w[i]), .frame_done(done_w[i])
        );

        // FIFO: pops at the edge that sees read_en, data valid the next cycle, junk otherwise
        always @(posedge clk) pop_now <= rd_w[i];
        always @(negedge clk) begin
            if (pop_now && fq.size() > 0) fd = fq.pop_front();
            else fd = 4'($urandom);
            fe = (fq.size() == 0);
        end

        // ph: 0 idle, 1 read, 2 load, 3 on the line (k = cycles since tx fell)
        int          ph = 0;
        int          k = 0;
        logic [15:0] fb = '1;
        logic        m_tx = 1'b1, m_rd = 1'b0, m_busy = 1'b0, m_done = 1'b0;

        always @(posedge clk) begin
            m_done = 1'b0;
            if (!rst) ph = 0;
            else begin
                case (ph)
                    0: if (enable && !fe) ph = 1;
                    1: ph = 2;
                    2: begin fb = frame_of(fd, PE, PO); k = 0; ph = 3; end
                    default: begin
                        k++;
                        if (k == FLEN) begin ph = 0; m_done = 1'b1; end
                    end
                endcase
            end
            m_rd   = (ph == 1);
            m_busy = (ph != 0);
            m_tx   = (ph == 3) ? fb[k/CPB] : 1'b1;
        end

        always @(negedge clk) begin
            chk("tx", i, tx_w[i], m_tx);
            chk("read_en", i, rd_w[i], m_rd);
            chk("busy", i, busy_w[i], m_busy);
            chk("frame_done", i, done_w[i], m_done);
        end
    end

    task automatic push(input logic [3:0] w);
        g_inst[0].fq.push_back(w);
        g_inst[1].fq.push_back(w);
        g_inst[2].fq.push_back(w);
    endtask

    function automatic int qsum();
        return g_inst[0].fq.size() + g_inst[1].fq.size() + g_inst[2].fq.size();
    endfunction

    task automatic wait_fall(input int i);
        int n = 0;
        while (tx_w[i] !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        chk("fall_timeout", i, n < 300, 1);
    endtask

    // entered on the first negedge with tx low; samples each bit mid-way
    task automatic frame_bits(input int i, input logic [15:0] eb, input int nb, input int len);
        int c;
        repeat (2) @(negedge clk);
        for (int j = 0; j < nb; j++) begin
            chk("frame_bit", i, tx_w[i], eb[j]);
            if (j < nb - 1) repeat (CPB) @(negedge clk);
        end
        c = CPB * (nb - 1) + 2;
        while (done_w[i] !== 1'b1 && c < 300) begin @(negedge clk); c++; end
        chk("frame_len", i, c, len);
    endtask

    task automatic gap(input int i, input int exp);
        int run = 0, n = 0;
        bit sd = 0;
        wait_fall(i);
        while (n < 300) begin
            @(negedge clk); n++;
            if (done_w[i] === 1'b1) sd = 1;
            if (tx_w[i] === 1'b1) run++;
            else if (sd) break;
            else run = 0;
        end
        chk("gap", i, run, exp);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy_w != '0 || qsum() != 0) && n < lim) begin @(negedge clk); n++; end
        chk("idle_timeout", 0, n < lim, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        push(4'hA);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_tx", 0, tx_w, 3'b111);
            chk("rst_busy", 0, busy_w, 3'b000);
            chk("rst_rd", 0, rd_w, 3'b000);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("first_read", 0, rd_w, 3'b111);
        fork
            begin wait_fall(0); frame_bits(0, 16'b110100, 6, 24); end
            begin wait_fall(1); frame_bits(1, 16'b11010100, 8, 32); end
            begin wait_fall(2); frame_bits(2, 16'b1110100, 7, 28); end
        join
        wait_idle(200);

        push(4'h7);
        fork
            begin wait_fall(0); frame_bits(0, 16'b101110, 6, 24); end
            begin wait_fall(1); frame_bits(1, 16'b11101110, 8, 32); end
            begin wait_fall(2); frame_bits(2, 16'b1001110, 7, 28); end
        join
        wait_idle(200);

        push(4'h3);
        push(4'hC);
        fork
            begin gap(0, 7);  frame_bits(0, 16'b111000, 6, 24); end
            begin gap(1, 11); frame_bits(1, 16'b11011000, 8, 32); end
            begin gap(2, 11); frame_bits(2, 16'b1111000, 7, 28); end
        join
        wait_idle(200);

        enable = 1'b0;
        push(4'h9);
        repeat (40) @(negedge clk);
        chk("gated_busy", 0, busy_w, 3'b000);
        chk("gated_tx", 0, tx_w, 3'b111);
        push(4'h6);
        enable = 1'b1;
        wait_fall(0);
        repeat (6) @(negedge clk);
        enable = 1'b0;
        repeat (60) @(negedge clk);
        chk("drop_en_busy", 0, busy_w, 3'b000);
        chk("drop_en_q0", 0, g_inst[0].fq.size(), 1);
        chk("drop_en_q1", 1, g_inst[1].fq.size(), 1);
        chk("drop_en_q2", 2, g_inst[2].fq.size(), 1);

        push(4'h5);
        enable = 1'b1;
        wait_fall(0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", 0, tx_w, 3'b111);
        chk("midrst_busy", 0, busy_w, 3'b000);
        chk("midrst_done", 0, done_w, 3'b000);
        rst = 1'b1;
        wait_fall(0);
        frame_bits(0, 16'b101010, 6, 24);
        wait_idle(200);

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) push(4'($urandom));
            enable = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 299) != 0);
        end
        rst = 1'b1;
        enable = 1'b1;
        wait_idle(6000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
